// File: rtl/gshare_bpred_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gshare_bpred_pkg
// Description : Shared defaults, indexing-mode encodings and counter-init
//               helper for the gshare branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package gshare_bpred_pkg;

    localparam int c_DEF_ENTRIES   = 1024;
    localparam int c_DEF_HIST_BITS = 8;
    localparam int c_DEF_CNT_BITS  = 2;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    // Weakly not-taken: the value just below the counter midpoint.
    function automatic int cnt_init(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gshare_bpred_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Combinational next-value logic for a width-parametrised
//               up/down counter that saturates at 0 and at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (en) begin
            if (up) begin
                if (cur != {WIDTH{1'b1}}) nxt = cur + WIDTH'(1);
            end else begin
                if (cur != {WIDTH{1'b0}}) nxt = cur - WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gshare_bpred.sv
`default_nettype none
// ============================================================================
// Module      : gshare_bpred
// Description : Zero-latency gshare/bimodal direction predictor with a
//               direct-mapped BTB and update/mispredict statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_bpred
    import gshare_bpred_pkg::*;
#(
    parameter int ENTRIES   = c_DEF_ENTRIES,
    parameter int HIST_BITS = c_DEF_HIST_BITS,
    parameter int CNT_BITS  = c_DEF_CNT_BITS,
    parameter int MODE      = MODE_GSHARE,
    localparam int IDX_W    = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_bpred_i,
    output logic             taken_bpred_o,
    output logic             hit_bpred_o,
    output logic [31:0]      target_bpred_o,
    output logic [IDX_W-1:0] idx_bpred_o,
    input  logic             upd_valid_bpred_i,
    input  logic [31:0]      upd_pc_bpred_i,
    input  logic [IDX_W-1:0] upd_idx_bpred_i,
    input  logic             upd_taken_bpred_i,
    input  logic [31:0]      upd_target_bpred_i,
    input  logic             upd_mispred_bpred_i,
    output logic [15:0]      upd_cnt_bpred_o,
    output logic [15:0]      mispred_cnt_bpred_o
);

    localparam int c_TAG_W    = 32 - IDX_W - 2;
    localparam int c_CNT_INIT = cnt_init(CNT_BITS);

    logic [CNT_BITS-1:0] r_pht        [ENTRIES];
    logic [ENTRIES-1:0]  r_btb_valid;
    logic [c_TAG_W-1:0]  r_btb_tag    [ENTRIES];
    logic [31:0]         r_btb_target [ENTRIES];
    logic [HIST_BITS-1:0] r_ghr;
    logic [15:0]         r_upd_cnt;
    logic [15:0]         r_mispred_cnt;

    logic [IDX_W-1:0]    w_sel;
    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W-1:0]    w_upd_sel;
    logic [CNT_BITS-1:0] w_pht_rd;
    logic [CNT_BITS-1:0] w_pht_nxt;
    logic [15:0]         w_upd_cnt_nxt;
    logic [15:0]         w_mispred_cnt_nxt;
    logic                w_hit;
    logic                w_unused_ok;

    assign w_sel     = pc_bpred_i[IDX_W+1:2];
    assign w_upd_sel = upd_pc_bpred_i[IDX_W+1:2];

    generate
        if (MODE == MODE_GSHARE) begin : g_gshare
            assign w_idx = w_sel ^ IDX_W'(r_ghr);
        end else begin : g_bimodal
            assign w_idx = w_sel;
        end
    endgenerate

    // Lookup reads the committed state only, so a same-cycle update is invisible until the next edge.
    assign w_pht_rd       = r_pht[w_idx];
    assign w_hit          = r_btb_valid[w_sel] && (r_btb_tag[w_sel] == pc_bpred_i[31:IDX_W+2]);
    assign hit_bpred_o    = w_hit;
    assign taken_bpred_o  = w_hit & w_pht_rd[CNT_BITS-1];
    assign target_bpred_o = w_hit ? r_btb_target[w_sel] : 32'h0;
    assign idx_bpred_o    = w_idx;

    assign upd_cnt_bpred_o     = r_upd_cnt;
    assign mispred_cnt_bpred_o = r_mispred_cnt;

    sat_counter #(.WIDTH(CNT_BITS)) u_pht_cnt (
        .cur (r_pht[upd_idx_bpred_i]),
        .en  (1'b1),
        .up  (upd_taken_bpred_i),
        .nxt (w_pht_nxt)
    );

    sat_counter #(.WIDTH(16)) u_upd_cnt (
        .cur (r_upd_cnt),
        .en  (1'b1),
        .up  (1'b1),
        .nxt (w_upd_cnt_nxt)
    );

    sat_counter #(.WIDTH(16)) u_mispred_cnt (
        .cur (r_mispred_cnt),
        .en  (upd_mispred_bpred_i),
        .up  (1'b1),
        .nxt (w_mispred_cnt_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_pht[i] <= CNT_BITS'(c_CNT_INIT);
            end
        end else if (upd_valid_bpred_i) begin
            r_pht[upd_idx_bpred_i] <= w_pht_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btb_valid   <= '0;
            r_ghr         <= '0;
            r_upd_cnt     <= '0;
            r_mispred_cnt <= '0;
        end else if (upd_valid_bpred_i) begin
            if (upd_taken_bpred_i) r_btb_valid[w_upd_sel] <= 1'b1;
            r_ghr         <= HIST_BITS'({r_ghr, upd_taken_bpred_i});
            r_upd_cnt     <= w_upd_cnt_nxt;
            r_mispred_cnt <= w_mispred_cnt_nxt;
        end
    end

    // Tag/target need no reset: the valid flops gate every read.
    always_ff @(posedge clk) begin
        if (reset && upd_valid_bpred_i && upd_taken_bpred_i) begin
            r_btb_tag[w_upd_sel]    <= upd_pc_bpred_i[31:IDX_W+2];
            r_btb_target[w_upd_sel] <= upd_target_bpred_i;
        end
    end

    assign w_unused_ok = ^{pc_bpred_i[1:0], upd_pc_bpred_i[1:0], r_ghr};

endmodule
`default_nettype wire

// File: doc/gshare_bpred.md
GSHARE_BPRED -- requirements
Module: gshare_bpred

Interface
REQ-001 Parameter ENTRIES, default 1024, sets PHT/BTB depth; it SHALL be a power of two and at least 16; IDX_W = log2(ENTRIES).
REQ-002 Parameter HIST_BITS, default 8, sets global history register (GHR) width; it SHALL be at most IDX_W.
REQ-003 Parameter CNT_BITS, default 2, sets saturating counter width; it SHALL be at least 1.
REQ-004 Parameter MODE, default 1, selects indexing: 0 = bimodal, 1 = gshare.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 pc_bpred_i  input  32  fetch-stage PC to look up.
REQ-008 taken_bpred_o  output  1  predicted taken.
REQ-009 hit_bpred_o  output  1  BTB holds a valid, tag-matching entry.
REQ-010 target_bpred_o  output  32  predicted target.
REQ-011 idx_bpred_o  output  IDX_W  PHT index used; the pipeline carries it to resolution.
REQ-012 upd_valid_bpred_i  input  1  a resolved branch is presented this cycle.
REQ-013 upd_pc_bpred_i  input  32  PC of the resolved branch.
REQ-014 upd_idx_bpred_i  input  IDX_W  idx_bpred_o captured at that branch's lookup.
REQ-015 upd_taken_bpred_i  input  1  actual outcome.
REQ-016 upd_target_bpred_i  input  32  actual taken target.
REQ-017 upd_mispred_bpred_i  input  1  direction or target was mispredicted.
REQ-018 upd_cnt_bpred_o  output  16  count of accepted updates.
REQ-019 mispred_cnt_bpred_o  output  16  count of mispredicted updates.

Function
REQ-020 Index: idx = pc[IDX_W+1:2] XOR GHR zero-extended to IDX_W when MODE=1; idx = pc[IDX_W+1:2] when MODE=0.
REQ-021 BTB entry selection: pc[IDX_W+1:2]; stored tag = pc[31:IDX_W+2].
REQ-022 Lookup SHALL be combinational (zero latency), so the result is usable in the same fetch cycle.
REQ-023 hit_bpred_o = valid[btb_sel] AND tag match.
REQ-024 taken_bpred_o = hit_bpred_o AND the MSB of PHT[idx].
REQ-025 target_bpred_o = the stored target on a hit, otherwise 32'h0.
REQ-026 On an update, PHT[upd_idx] SHALL increment, saturating at 2^CNT_BITS-1, when taken; it SHALL decrement, saturating at 0, when not taken.
REQ-027 On an update with taken=1, the BTB entry for upd_pc SHALL be written: valid=1, tag, target. A not-taken update SHALL leave the BTB unchanged.
REQ-028 On every update, GHR SHALL become {GHR[HIST_BITS-2:0], upd_taken}. GHR is non-speculative; lookups use the committed GHR.
REQ-029 A lookup and an update in the same cycle to the same index SHALL return the pre-update values; the new values are visible the next cycle.
REQ-030 upd_cnt SHALL increment on each update; mispred_cnt SHALL increment on an update with mispred=1. Both SHALL saturate at 16'hFFFF.
REQ-031 When upd_valid_bpred_i=0, the PHT, BTB, GHR and both counters SHALL be unchanged.

Reset
REQ-032 While reset=0: every PHT counter = 2^(CNT_BITS-1)-1 (weakly not-taken, 01 at default width); all BTB valid bits = 0; GHR = 0; both counters = 0.
REQ-033 Outputs during and immediately after reset SHALL be: taken=0, hit=0, target=0, idx = pc[IDX_W+1:2].
REQ-034 Reset asserted mid-operation SHALL discard any update presented in that cycle.

Structure
REQ-035 The shared package SHALL hold the default parameter values, the counter-init function and the MODE encodings (MODE_BIMODAL=0, MODE_GSHARE=1).
REQ-036 One sub-module, sat_counter (width-parametrised increment/decrement with saturation), SHALL be used for PHT update and for the statistics counters.
REQ-037 BTB tag and target storage SHALL be behavioural arrays; valid bits SHALL be flops so that reset clears them.

Verification
REQ-038 Reset, then look up pc=0x40 -> taken=0, hit=0, target=0, idx=0x010 (MODE=0).
REQ-039 MODE=0: one update for pc=0x40 with taken=1, target=0x100 -> next-cycle lookup gives taken=1, hit=1, target=0x100; upd_cnt=1.
REQ-040 MODE=0: from counter 11, apply four not-taken updates -> counter 00 after the third update and still 00 after the fourth; lookup gives taken=0, hit=1.
REQ-041 MODE=1: reset, one taken update -> GHR=0x01; lookup pc=0x40 gives idx=0x011.
REQ-042 Same-cycle lookup and update to the same index, counter 01 with taken=1 -> that cycle taken=0; the next cycle taken=1.
REQ-043 Reset pulsed low mid-stream with mispred_cnt=5 -> all counters 0, hit=0 for pc=0x40, GHR=0.
